// File: rtl/seg_scan_decoder.sv
// Recovers 8 hex digits from sampled, multiplexed 7-segment anode/segment lines and presents each complete scan as one frame.
// Latency: valid_o rises one cycle after the capture that completes the 8-digit mask (plus SYNC_STAGES input sync and the stability run).
// Backpressure: frame is held on val_o/dp_o/err_o until ready_i; a frame that completes while the previous one is unaccepted is dropped and sets overrun_o.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk_100MHz_i,
  input  logic        rst_n,
  input  logic [7:0]  an_i,
  input  logic [7:0]  hex_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] val_o,
  output logic [7:0]  dp_o,
  output logic [7:0]  err_o,
  output logic        overrun_o,
  input  logic        overrun_clr_i
);

  localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] RUN_M1  = 8'(STABLE_CYCLES - 1);

  typedef enum logic {COLLECT = 1'b0, PRESENT = 1'b1} state_t;

  state_t      state_q, state_nx;
  logic [7:0]  an_sync  [SYNC_STAGES];
  logic [7:0]  hex_sync [SYNC_STAGES];
  logic [15:0] s, p;
  logic [7:0]  run_cnt;
  logic        cap_ok;
  logic [7:0]  cap_sel;
  logic [4:0]  dec;
  logic [7:0]  mask_q, mask_cap;
  logic [31:0] nib_q, nib_nx;
  logic [7:0]  dp_q, dp_nx, err_q, err_nx;
  logic        frame_done, load_frame, drop_frame;

  // Active-low {G..A} pattern to {err, nibble}; unknown patterns decode to nibble 0 with err set.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h40:   seg_decode = 5'h00;
      7'h79:   seg_decode = 5'h01;
      7'h24:   seg_decode = 5'h02;
      7'h30:   seg_decode = 5'h03;
      7'h19:   seg_decode = 5'h04;
      7'h12:   seg_decode = 5'h05;
      7'h02:   seg_decode = 5'h06;
      7'h78:   seg_decode = 5'h07;
      7'h00:   seg_decode = 5'h08;
      7'h10:   seg_decode = 5'h09;
      7'h08:   seg_decode = 5'h0A;
      7'h03:   seg_decode = 5'h0B;
      7'h46:   seg_decode = 5'h0C;
      7'h21:   seg_decode = 5'h0D;
      7'h06:   seg_decode = 5'h0E;
      7'h0E:   seg_decode = 5'h0F;
      default: seg_decode = 5'h10;
    endcase
  endfunction

  // Synchronize the asynchronous display lines; reset value is the blank pattern.
  always_ff @(posedge clk_100MHz_i) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        an_sync[i]  <= 8'hFF;
        hex_sync[i] <= 8'hFF;
      end
    end else begin
      an_sync[0]  <= an_i;
      hex_sync[0] <= hex_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        an_sync[i]  <= an_sync[i-1];
        hex_sync[i] <= hex_sync[i-1];
      end
    end
  end

  assign s = {an_sync[SYNC_STAGES-1], hex_sync[SYNC_STAGES-1]};

  // Track how long the synchronized sample has been stable; saturates so the strobe fires once per run.
  always_ff @(posedge clk_100MHz_i) begin
    if (!rst_n) begin
      p       <= 16'hFFFF;
      run_cnt <= 8'd0;
    end else begin
      p <= s;
      if (s != p)                run_cnt <= 8'd1;
      else if (run_cnt != RUN_MAX) run_cnt <= run_cnt + 8'd1;
    end
  end

  // Qualify the capture (one-hot-low anode only) and form the digit store as it will be after this cycle.
  always_comb begin
    cap_sel  = ~s[15:8];
    cap_ok   = (s == p) && (run_cnt == RUN_M1) && ($countones(cap_sel) == 1);
    dec      = seg_decode(s[6:0]);
    nib_nx   = nib_q;
    dp_nx    = dp_q;
    err_nx   = err_q;
    mask_cap = mask_q;
    if (cap_ok) begin
      mask_cap = mask_q | cap_sel;
      for (int k = 0; k < 8; k++) begin
        if (cap_sel[k]) begin
          nib_nx[4*k +: 4] = dec[3:0];
          err_nx[k]        = dec[4];
          dp_nx[k]         = ~s[7];
        end
      end
    end
    frame_done = &mask_cap;
  end

  // FSM state register.
  always_ff @(posedge clk_100MHz_i) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_nx;
  end

  // FSM next state: leave PRESENT only on a handshake with no new frame completing.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      COLLECT: if (frame_done)             state_nx = PRESENT;
      PRESENT: if (ready_i && !frame_done) state_nx = COLLECT;
      default:                             state_nx = COLLECT;
    endcase
  end

  // FSM outputs: frame valid, load of a completed frame, and drop on overrun.
  always_comb begin
    valid_o    = (state_q == PRESENT);
    load_frame = frame_done && ((state_q == COLLECT) || ready_i);
    drop_frame = frame_done && (state_q == PRESENT) && !ready_i;
  end

  // Digit store, capture mask, presented frame and sticky overrun flag.
  always_ff @(posedge clk_100MHz_i) begin
    if (!rst_n) begin
      mask_q    <= 8'h00;
      nib_q     <= 32'h0;
      dp_q      <= 8'h00;
      err_q     <= 8'h00;
      val_o     <= 32'h0;
      dp_o      <= 8'h00;
      err_o     <= 8'h00;
      overrun_o <= 1'b0;
    end else begin
      mask_q <= frame_done ? 8'h00 : mask_cap;
      nib_q  <= nib_nx;
      dp_q   <= dp_nx;
      err_q  <= err_nx;
      if (load_frame) begin
        val_o <= nib_nx;
        dp_o  <= dp_nx;
        err_o <= err_nx;
      end
      if (drop_frame)         overrun_o <= 1'b1;
      else if (overrun_clr_i) overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of full-scan frames plus hand sequences
// for the stability threshold, junk anode patterns, overrun and mid-frame reset.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  an_i, hex_i;
  logic        ready_i, overrun_clr_i;
  logic        valid_o, overrun_o;
  logic [31:0] val_o;
  logic [7:0]  dp_o, err_o;

  always #5 clk = ~clk;

  seg_scan_decoder dut (
    .clk_100MHz_i (clk),
    .rst_n        (rst_n),
    .an_i         (an_i),
    .hex_i        (hex_i),
    .ready_i      (ready_i),
    .valid_o      (valid_o),
    .val_o        (val_o),
    .dp_o         (dp_o),
    .err_o        (err_o),
    .overrun_o    (overrun_o),
    .overrun_clr_i(overrun_clr_i)
  );

  typedef struct {
    logic [63:0] hexes;   // {d7,...,d0} hex_i bytes
    logic [31:0] exp_val;
    logic [7:0]  exp_dp;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs [4];

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int vld_cycles = 0;
  logic [31:0] last_val = 32'h0;
  logic [7:0]  last_dp = 8'h0, last_err = 8'h0;

  // Record every accepted frame and every cycle valid_o is high.
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      vld_cycles++;
      if (ready_i) begin
        acc_cnt++;
        last_val = val_o;
        last_dp  = dp_o;
        last_err = err_o;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_digit(input int k, input logic [7:0] h, input int n);
    logic [7:0] one;
    one   = 8'h01;
    an_i  = ~(one << k);
    hex_i = h;
    cyc(n);
  endtask

  task automatic blank(input int n);
    an_i  = 8'hFF;
    hex_i = 8'hFF;
    cyc(n);
  endtask

  task automatic scan(input logic [63:0] hx, input int first, input int last, input bit junk);
    for (int k = first; k <= last; k++) begin
      if (junk) begin
        an_i  = 8'hFF;
        hex_i = hx[8*k +: 8];
        cyc(40);
        an_i  = 8'hFC;
        cyc(40);
      end
      drive_digit(k, hx[8*k +: 8], 40);
    end
  endtask

  int a0, v0;

  initial begin
    vecs[0] = '{64'hF9A4B099_8883C6A1, 32'h1234ABCD, 8'h00, 8'h00};
    vecs[1] = '{64'h92929292_FF929240, 32'h55550550, 8'h01, 8'h08};
    vecs[2] = '{64'h92929292_7F929240, 32'h55550550, 8'h09, 8'h08};
    vecs[3] = '{64'h868E1080_F882C0FE, 32'hEF987600, 8'h20, 8'h01};

    rst_n = 1'b0; an_i = 8'hFF; hex_i = 8'hFF; ready_i = 1'b1; overrun_clr_i = 1'b0;
    cyc(3);
    @(negedge clk);
    chk("reset_valid", {31'h0, valid_o}, 32'h0);
    chk("reset_val", val_o, 32'h0);
    chk("reset_dp", {24'h0, dp_o}, 32'h0);
    chk("reset_err", {24'h0, err_o}, 32'h0);
    chk("reset_overrun", {31'h0, overrun_o}, 32'h0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    // Table of full scans with ready_i high: one single-cycle valid per frame.
    for (int i = 0; i < 4; i++) begin
      a0 = acc_cnt; v0 = vld_cycles;
      scan(vecs[i].hexes, 0, 7, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_frames", i), acc_cnt - a0, 1);
      chk($sformatf("vec%0d_vld_cycles", i), vld_cycles - v0, 1);
      chk($sformatf("vec%0d_val", i), last_val, vecs[i].exp_val);
      chk($sformatf("vec%0d_dp", i), {24'h0, last_dp}, {24'h0, vecs[i].exp_dp});
      chk($sformatf("vec%0d_err", i), {24'h0, last_err}, {24'h0, vecs[i].exp_err});
    end

    // Stability threshold: 15 cycles is not enough, 16 captures.
    a0 = acc_cnt;
    scan(vecs[0].hexes, 0, 6, 1'b0);
    drive_digit(7, 8'h90, 15);
    blank(40);
    @(negedge clk);
    chk("run15_no_frame", acc_cnt - a0, 0);
    chk("run15_valid", {31'h0, valid_o}, 32'h0);
    drive_digit(7, 8'h90, 16);
    blank(40);
    @(negedge clk);
    chk("run16_frame", acc_cnt - a0, 1);
    chk("run16_val", last_val, 32'h9234ABCD);

    // Blank and multi-low anode patterns between digits are ignored.
    a0 = acc_cnt;
    scan(vecs[0].hexes, 0, 7, 1'b1);
    @(negedge clk);
    chk("junk_frame", acc_cnt - a0, 1);
    chk("junk_val", last_val, 32'h1234ABCD);
    chk("junk_err", {24'h0, last_err}, 32'h0);

    // Overrun: consumer stalled across two complete scans.
    ready_i = 1'b0;
    scan(vecs[0].hexes, 0, 7, 1'b0);
    @(negedge clk);
    chk("ovr_first_valid", {31'h0, valid_o}, 32'h1);
    chk("ovr_first_val", val_o, 32'h1234ABCD);
    chk("ovr_not_yet", {31'h0, overrun_o}, 32'h0);
    scan(vecs[3].hexes, 0, 7, 1'b0);
    @(negedge clk);
    chk("ovr_set", {31'h0, overrun_o}, 32'h1);
    chk("ovr_held_val", val_o, 32'h1234ABCD);
    chk("ovr_held_dp", {24'h0, dp_o}, 32'h0);
    chk("ovr_held_valid", {31'h0, valid_o}, 32'h1);
    cyc(1);
    overrun_clr_i = 1'b1;
    cyc(1);
    overrun_clr_i = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", {31'h0, overrun_o}, 32'h0);
    cyc(1);
    a0 = acc_cnt;
    ready_i = 1'b1;
    cyc(2);
    @(negedge clk);
    chk("ovr_accept", acc_cnt - a0, 1);
    chk("ovr_accept_val", last_val, 32'h1234ABCD);
    chk("ovr_valid_drop", {31'h0, valid_o}, 32'h0);

    // Reset mid-frame with a pending frame discards both.
    cyc(1);
    ready_i = 1'b0;
    scan(vecs[3].hexes, 0, 7, 1'b0);
    @(negedge clk);
    chk("rst_pending_valid", {31'h0, valid_o}, 32'h1);
    cyc(1);
    scan(vecs[0].hexes, 0, 4, 1'b0);
    blank(2);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_val", val_o, 32'h0);
    chk("rst_dp", {24'h0, dp_o}, 32'h0);
    chk("rst_err", {24'h0, err_o}, 32'h0);
    cyc(1);
    ready_i = 1'b1;
    a0 = acc_cnt;
    scan(vecs[0].hexes, 5, 7, 1'b0);
    @(negedge clk);
    chk("rst_partial_no_frame", acc_cnt - a0, 0);
    chk("rst_partial_val", val_o, 32'h0);
    cyc(1);
    scan(vecs[0].hexes, 0, 4, 1'b0);
    @(negedge clk);
    chk("rst_fresh_frame", acc_cnt - a0, 1);
    chk("rst_fresh_val", last_val, 32'h1234ABCD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
